dbg_reg_scanner: RTL
====================

// Module: dbg_reg_scanner
// PURPOSE
//  Parametrised debug read-out engine between the multi-cycle CPU debug port (in_addr/out_data)
//  and a downstream consumer (display/UART). It drives the CPU debug address and waits a
//  programmable settle time. It then captures the returned word and hands {addr,data} out over
//  a valid/ready handshake. Modes: manual single address, continuous wrap-around scan, and
//  one-shot snapshot of registers 0..DEPTH-1 with a done pulse.
// PARAMETERS
//  ADDR_W   5   width of debug address
//  DATA_W   32  width of debug data word
//  DEPTH    32  number of addresses scanned (2..2**ADDR_W); scan covers 0..DEPTH-1
//  DWELL    4   settle cycles between dbg_addr update and capture (>=1)
// PORTS
//  clk_100Mhz  in   1       system clock, all logic on rising edge
//  rst_n       in   1       asynchronous active-low reset
//  mode        in   2       00 manual, 01 continuous scan, 10 snapshot, 11 reserved (treated as 00)
//  man_addr    in   ADDR_W  address used in manual mode
//  start       in   1       snapshot trigger, level sampled in IDLE
//  dbg_addr    out  ADDR_W  to CPU in_addr
//  dbg_data    in   DATA_W  from CPU out_data
//  out_valid   out  1       {out_addr,out_data} valid
//  out_ready   in   1       consumer accepts when out_valid&&out_ready
//  out_addr    out  ADDR_W  address of captured word
//  out_data    out  DATA_W  captured word
//  busy        out  1       1 in any state except IDLE
//  done        out  1       one-cycle pulse after last snapshot word accepted
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, dbg_addr=0, out_valid=0, out_addr=0, out_data=0,
//    busy=0, done=0, settle counter=0, scan index=0. Reset mid-scan aborts at once; no done.
//  - FSM states: IDLE, SETTLE, HOLD, DONE.
//  - IDLE: mode is sampled here only.
//    - 01: go to SETTLE with dbg_addr=0.
//    - 10 && start: go to SETTLE with dbg_addr=0.
//    - 00/11: go to SETTLE with dbg_addr=man_addr.
//    - Changes to mode during SETTLE/HOLD do not take effect until the next IDLE.
//  - SETTLE: the counter counts 1..DWELL. On the cycle the count reaches DWELL, out_data<=dbg_data
//    and out_addr<=dbg_addr are registered, out_valid<=1, and the FSM goes to HOLD. Latency from
//    address update to out_valid rising is DWELL+1 edges.
//  - Manual mode: if man_addr != dbg_addr during SETTLE, dbg_addr reloads and the counter restarts at 0.
//  - HOLD: out_valid, out_addr and out_data are held stable and dbg_addr is frozen until
//    out_valid&&out_ready. On acceptance, out_valid<=0 in the same edge, then:
//    - manual: back to IDLE (re-reads on the next pass; a continuous refresh of man_addr).
//    - continuous: if mode still 01, dbg_addr<=(dbg_addr==DEPTH-1)?0:dbg_addr+1 and go to SETTLE;
//      otherwise go to IDLE.
//    - snapshot: if dbg_addr==DEPTH-1, go to DONE; otherwise increment and go to SETTLE.
//  - DONE: done=1 for exactly one cycle, then IDLE. start still high in IDLE retriggers; the
//    consumer must drop start to avoid a repeat snapshot.
//  - out_ready while out_valid=0 is ignored. There is no out_data bypass; data comes only from a capture.
//  - Increments wrap within 0..DEPTH-1 only. There is no arithmetic overflow into ADDR_W when
//    DEPTH < 2**ADDR_W.
//  - busy = (state != IDLE). done is registered.
// TESTING
//  1 reset: rst_n=0 asserted mid-HOLD -> all outputs 0 immediately (async), state IDLE, no done pulse.
//  2 manual, DWELL=4: man_addr=5'h03, CPU model returns 32'h0000_0033 -> out_valid rises 5 edges
//    later with out_addr=3, out_data=32'h33. Change man_addr to 7 during SETTLE -> capture is of
//    address 7 only.
//  3 continuous, out_ready=1: DEPTH=32 -> out_addr sequence 0,1,..,31,0,1 with no gaps; words
//    match the model reg[i]=i*4.
//  4 backpressure: hold out_ready=0 for 20 cycles in HOLD -> out_valid, out_addr, out_data and
//    dbg_addr all constant. Release -> exactly one transfer, then advance.
//  5 snapshot: mode=10, start pulse, DEPTH=8 -> 8 transfers addr 0..7, then done high for exactly
//    1 cycle, busy falls. A second start gives an identical sequence.
//  6 mode switch: go from 01 to 00 while at addr 12 in SETTLE -> addr 12 is still delivered, then
//    IDLE, then manual reads of man_addr.

Source files
------------

// File: rtl/dbg_reg_scanner.sv
// Debug read-out engine: drives the CPU debug address, waits DWELL settle cycles,
// captures the returned word and hands {addr,data} downstream over valid/ready.
module dbg_reg_scanner #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int DWELL  = 4
) (
    input  logic              i_clk_100Mhz,
    input  logic              i_rst_n,
    input  logic [1:0]        i_mode,
    input  logic [ADDR_W-1:0] i_man_addr,
    input  logic              i_start,
    output logic [ADDR_W-1:0] o_dbg_addr,
    input  logic [DATA_W-1:0] i_dbg_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [ADDR_W-1:0] o_out_addr,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_busy,
    output logic              o_done
);

    localparam int                CNT_W   = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DWELL);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [1:0] M_MAN  = 2'd0;
    localparam logic [1:0] M_CONT = 2'd1;
    localparam logic [1:0] M_SNAP = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        r_run;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_dbg_addr;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_addr;
    logic [DATA_W-1:0] r_out_data;
    logic              r_done;
    logic [ADDR_W-1:0] w_next_addr;

    // Wrap inside 0..DEPTH-1 so a short scan never walks into unused addresses
    assign w_next_addr = (r_dbg_addr == LAST) ? '0 : r_dbg_addr + ADDR_W'(1);

    always_ff @(posedge i_clk_100Mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_run       <= M_MAN;
            r_cnt       <= '0;
            r_dbg_addr  <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    case (i_mode)
                        2'b01: begin
                            r_run      <= M_CONT;
                            r_dbg_addr <= '0;
                            r_state    <= S_SETTLE;
                        end
                        2'b10: begin
                            if (i_start) begin
                                r_run      <= M_SNAP;
                                r_dbg_addr <= '0;
                                r_state    <= S_SETTLE;
                            end
                        end
                        default: begin
                            r_run      <= M_MAN;
                            r_dbg_addr <= i_man_addr;
                            r_state    <= S_SETTLE;
                        end
                    endcase
                end
                S_SETTLE: begin
                    // A manual address change restarts the settle window on the new address
                    if (r_run == M_MAN && i_man_addr != r_dbg_addr) begin
                        r_dbg_addr <= i_man_addr;
                        r_cnt      <= '0;
                    end else if (r_cnt == CNT_MAX) begin
                        r_out_data  <= i_dbg_data;
                        r_out_addr  <= r_dbg_addr;
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        case (r_run)
                            M_CONT: begin
                                if (i_mode == 2'b01) begin
                                    r_dbg_addr <= w_next_addr;
                                    r_state    <= S_SETTLE;
                                end else begin
                                    r_state <= S_IDLE;
                                end
                            end
                            M_SNAP: begin
                                if (r_dbg_addr == LAST) begin
                                    r_done  <= 1'b1;
                                    r_state <= S_DONE;
                                end else begin
                                    r_dbg_addr <= w_next_addr;
                                    r_state    <= S_SETTLE;
                                end
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_dbg_addr  = r_dbg_addr;
    assign o_out_valid = r_out_valid;
    assign o_out_addr  = r_out_addr;
    assign o_out_data  = r_out_data;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = r_done;

endmodule
